// File: rtl/mig_req_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mig_req_bridge                                                             |
// | Valid/ready request port to MIG app_* handshakes, with a credit-limited    |
// | in-order read response FIFO. Optional command counters: define            |
// | MIG_REQ_BRIDGE_STATS_EN to build stat_wr / stat_rd.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mig_req_bridge #(
  parameter int RD_DEPTH = 4
) (
  input  logic          ui_clk,
  input  logic          ui_clk_sync_rst,
  input  logic          init_calib_complete,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [27:0]   req_addr,
  input  logic [511:0]  req_wdata,
  input  logic [63:0]   req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [511:0]  rsp_data,
  output logic [27:0]   app_addr,
  output logic [2:0]    app_cmd,
  output logic          app_en,
  input  logic          app_rdy,
  output logic [511:0]  app_wdf_data,
  output logic [63:0]   app_wdf_mask,
  output logic          app_wdf_wren,
  output logic          app_wdf_end,
  input  logic          app_wdf_rdy,
  input  logic [511:0]  app_rd_data,
  input  logic          app_rd_data_valid,
  output logic          rd_err,
  output logic [31:0]   stat_wr,
  output logic [31:0]   stat_rd
);

  localparam int          CW      = $clog2(RD_DEPTH) + 1;
  localparam logic [CW:0] c_DEPTH = RD_DEPTH[CW:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [CW-1:0]               r_outstanding, w_outstanding_nxt;
  logic [CW-1:0]               r_count, w_count_nxt, w_wr_idx;
  logic [RD_DEPTH-1:0][511:0]  r_mem;
  logic                        w_accept, w_rd_hs, w_wr_done;
  logic                        w_push, w_pop, w_stray;
  logic                        w_app_en_nxt, w_wren_nxt, w_req_ready_nxt;
  logic                        w_unused;

  assign w_accept = req_valid & req_ready;
  assign w_push   = app_rd_data_valid & (r_outstanding != '0);
  assign w_stray  = app_rd_data_valid & (r_outstanding == '0);
  assign w_pop    = rsp_valid & rsp_ready;
  assign w_unused = &{1'b0, req_addr[2:0], w_wr_done};

  always_comb begin
    w_state_nxt  = r_state;
    w_app_en_nxt = app_en;
    w_wren_nxt   = app_wdf_wren;
    w_rd_hs      = 1'b0;
    w_wr_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = req_write ? S_WR : S_RD;
          w_app_en_nxt = 1'b1;
          w_wren_nxt   = req_write;
        end
      end
      S_WR: begin
        // Command and data handshakes retire independently.
        if (app_en && app_rdy)            w_app_en_nxt = 1'b0;
        if (app_wdf_wren && app_wdf_rdy)  w_wren_nxt   = 1'b0;
        if (!w_app_en_nxt && !w_wren_nxt) begin
          w_state_nxt = S_IDLE;
          w_wr_done   = 1'b1;
        end
      end
      S_RD: begin
        if (app_rdy) begin
          w_app_en_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          w_rd_hs      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_outstanding_nxt = r_outstanding + {{(CW-1){1'b0}}, w_rd_hs}
                                           - {{(CW-1){1'b0}}, w_push};
  assign w_count_nxt       = r_count + {{(CW-1){1'b0}}, w_push}
                                     - {{(CW-1){1'b0}}, w_pop};
  assign w_wr_idx          = r_count - {{(CW-1){1'b0}}, w_pop};

  // Reads in flight plus buffered responses may never exceed the FIFO depth.
  assign w_req_ready_nxt = (w_state_nxt == S_IDLE) && init_calib_complete &&
                           (({1'b0, w_outstanding_nxt} + {1'b0, w_count_nxt}) < c_DEPTH);

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_state       <= S_IDLE;
      r_outstanding <= '0;
      r_count       <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rd_err        <= 1'b0;
      app_en        <= 1'b0;
      app_wdf_wren  <= 1'b0;
      app_wdf_end   <= 1'b0;
      app_cmd       <= '0;
      app_addr      <= '0;
      app_wdf_data  <= '0;
      app_wdf_mask  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_count       <= w_count_nxt;
      req_ready     <= w_req_ready_nxt;
      rsp_valid     <= (w_count_nxt != '0);
      app_en        <= w_app_en_nxt;
      app_wdf_wren  <= w_wren_nxt;
      app_wdf_end   <= w_wren_nxt;
      if (w_accept) begin
        app_addr     <= {req_addr[27:3], 3'b000};
        app_cmd      <= req_write ? 3'd0 : 3'd1;
        app_wdf_data <= req_wdata;
        app_wdf_mask <= ~req_be;
      end
      if (w_stray) rd_err <= 1'b1;
    end
  end

  // Shift FIFO: entry 0 is the head and drives rsp_data directly.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_mem <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < RD_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push) r_mem[w_wr_idx[CW-2:0]] <= app_rd_data;
    end
  end

  assign rsp_data = r_mem[0];

`ifdef MIG_REQ_BRIDGE_STATS_EN
  logic [31:0] r_stat_wr, r_stat_rd;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_wr_done) r_stat_wr <= r_stat_wr + 32'd1;
      if (w_rd_hs)   r_stat_rd <= r_stat_rd + 32'd1;
    end
  end

  assign stat_wr = r_stat_wr;
  assign stat_rd = r_stat_rd;
`else
  assign stat_wr = '0;
  assign stat_rd = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mig_req_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mig_req_bridge                                                          |
// | Scoreboard bench for mig_req_bridge with a cycle-stepped MIG model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mig_req_bridge;

  localparam int RD_DEPTH = 4;

  logic          ui_clk = 1'b0;
  logic          ui_clk_sync_rst;
  logic          init_calib_complete;
  logic          req_valid, req_ready, req_write;
  logic [27:0]   req_addr;
  logic [511:0]  req_wdata;
  logic [63:0]   req_be;
  logic          rsp_valid, rsp_ready;
  logic [511:0]  rsp_data;
  logic [27:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [511:0]  app_wdf_data;
  logic [63:0]   app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [511:0]  app_rd_data;
  logic          app_rd_data_valid;
  logic          rd_err;
  logic [31:0]   stat_wr, stat_rd;

  always #5 ui_clk = ~ui_clk;

  mig_req_bridge #(.RD_DEPTH(RD_DEPTH)) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_be              (req_be),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .rd_err              (rd_err),
    .stat_wr             (stat_wr),
    .stat_rd             (stat_rd)
  );

  typedef struct {
    logic [27:0]  addr;
    logic [63:0]  mask;
    logic [511:0] data;
  } wr_exp_t;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [27:0]  mig_rd_q[$];
  logic [511:0] exp_rsp_q[$];
  wr_exp_t      exp_wr_q[$];

  function automatic logic [511:0] rd_pat(input logic [27:0] a);
    return {16{4'hA, a}};
  endfunction

  function automatic logic [511:0] wr_pat(input logic [27:0] a);
    return {16{4'h5, ~a}};
  endfunction

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    if (app_en && app_rdy && app_cmd == 3'd1) mig_rd_q.push_back(app_addr);
    @(posedge ui_clk);
    #1;
  endtask

  task automatic mig_return();
    logic [27:0] a;
    vectors++;
    if (mig_rd_q.size() == 0) begin
      miscompares++;
      $display("FAIL mig_return: got no read command, want one pending");
    end else begin
      a = mig_rd_q.pop_front();
      app_rd_data       = rd_pat(a);
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_timeout: got req_ready=%b want 1", name, req_ready);
    end
  endtask

  task automatic issue_read(input logic [27:0] a);
    req_write = 1'b0;
    req_addr  = a;
    req_valid = 1'b1;
    wait_ready("issue_read");
    exp_rsp_q.push_back(rd_pat({a[27:3], 3'b000}));
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    vectors++;
    if ({req_ready, app_en, app_wdf_wren, app_wdf_end, rsp_valid, rd_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {req_ready, app_en, app_wdf_wren, app_wdf_end, rsp_valid, rd_err});
    end
    vectors++;
    if ({app_addr, app_cmd, app_wdf_mask} !== '0) begin
      miscompares++;
      $display("FAIL reset_cmd: got addr=%h cmd=%h mask=%h want 0", app_addr, app_cmd, app_wdf_mask);
    end
    vectors++;
    if ({rsp_data, app_wdf_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got rsp=%h wdf=%h want 0", rsp_data, app_wdf_data);
    end
    vectors++;
    if ({stat_wr, stat_rd} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got wr=%0d rd=%0d want 0", stat_wr, stat_rd);
    end
  endtask

  task automatic test_calib_hold();
    logic [511:0] exp;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 28'h0000100;
    app_rdy   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (req_ready !== 1'b0 || app_en !== 1'b0) begin
        miscompares++;
        $display("FAIL calib_hold: got req_ready=%b app_en=%b want 0 0", req_ready, app_en);
      end
      tick();
    end
    init_calib_complete = 1'b1;
    wait_ready("calib");
    exp_rsp_q.push_back(rd_pat(28'h0000100));
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'd1, 28'h0000100}) begin
      miscompares++;
      $display("FAIL calib_issue: got en=%b cmd=%0d addr=%h want 1 1 0000100", app_en, app_cmd, app_addr);
    end
    tick();
    vectors++;
    if (app_en !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL calib_done: got en=%b req_ready=%b want 0 1", app_en, req_ready);
    end
    mig_return();
    exp = exp_rsp_q.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
      miscompares++;
      $display("FAIL calib_rsp: got valid=%b data=%h want 1 %h", rsp_valid, rsp_data, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL calib_rsp_drain: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_masked_write();
    wr_exp_t e;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    req_write   = 1'b1;
    req_addr    = 28'h0000015;
    req_be      = 64'h00000000_0000000F;
    req_wdata   = wr_pat(28'h0000015);
    req_valid   = 1'b1;
    wait_ready("masked_write");
    exp_wr_q.push_back('{addr: 28'h0000010, mask: 64'hFFFFFFFF_FFFFFFF0, data: wr_pat(28'h0000015)});
    tick();
    req_valid = 1'b0;
    e = exp_wr_q.pop_front();
    vectors++;
    if ({app_en, app_wdf_wren, app_wdf_end, app_cmd} !== {3'b111, 3'd0}) begin
      miscompares++;
      $display("FAIL mwr_strobes: got en/wren/end=%b cmd=%0d want 111 0",
               {app_en, app_wdf_wren, app_wdf_end}, app_cmd);
    end
    vectors++;
    if (app_addr !== e.addr || app_wdf_mask !== e.mask) begin
      miscompares++;
      $display("FAIL mwr_addr_mask: got %h %h want %h %h", app_addr, app_wdf_mask, e.addr, e.mask);
    end
    vectors++;
    if (app_wdf_data !== e.data) begin
      miscompares++;
      $display("FAIL mwr_data: got %h want %h", app_wdf_data, e.data);
    end
    tick();
    vectors++;
    if ({app_en, app_wdf_wren, req_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL mwr_done: got en/wren/ready=%b want 001", {app_en, app_wdf_wren, req_ready});
    end
  endtask

  task automatic test_split_write();
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    req_write   = 1'b1;
    req_addr    = 28'h0000200;
    req_be      = '1;
    req_wdata   = wr_pat(28'h0000200);
    req_valid   = 1'b1;
    wait_ready("split_write");
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      vectors++;
      if (app_en !== (k <= 3) || app_wdf_wren !== (k <= 5) ||
          app_wdf_end !== app_wdf_wren || req_ready !== (k >= 6)) begin
        miscompares++;
        $display("FAIL split_write k=%0d: got en/wren/end/ready=%b want %b", k,
                 {app_en, app_wdf_wren, app_wdf_end, req_ready},
                 {k <= 3, k <= 5, k <= 5, k >= 6});
      end
      app_rdy     = (k == 3);
      app_wdf_rdy = (k == 5);
      tick();
    end
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
  endtask

  task automatic test_credit_limit();
    logic [511:0] exp;
    int           n;
    rsp_ready = 1'b0;
    app_rdy   = 1'b1;
    for (int i = 0; i < 4; i++) issue_read(28'h0001000 + (28'(i) << 3));
    for (int i = 0; i < 4; i++) mig_return();
    req_write = 1'b0;
    req_addr  = 28'h0001040;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (req_ready !== 1'b0 || app_en !== 1'b0) begin
        miscompares++;
        $display("FAIL credit_block: got req_ready=%b app_en=%b want 0 0", req_ready, app_en);
      end
      tick();
    end
    exp = exp_rsp_q.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
      miscompares++;
      $display("FAIL credit_rsp0: got valid=%b data=%h want 1 %h", rsp_valid, rsp_data, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_release: got req_ready=%b want 1", req_ready);
    end
    exp_rsp_q.push_back(rd_pat(28'h0001040));
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'd1, 28'h0001040}) begin
      miscompares++;
      $display("FAIL credit_5th: got en=%b cmd=%0d addr=%h want 1 1 0001040", app_en, app_cmd, app_addr);
    end
    tick();
    mig_return();
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      exp = exp_rsp_q.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
        miscompares++;
        $display("FAIL credit_order j=%0d: got valid=%b data=%h want 1 %h", j, rsp_valid, rsp_data, exp);
      end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    issue_read(28'h0002000);
    issue_read(28'h0002008);
    ui_clk_sync_rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, app_en, rsp_valid, rd_err} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_async: got ready/en/rsp_valid/rd_err=%b want 0000",
               {req_ready, app_en, rsp_valid, rd_err});
    end
    tick();
    ui_clk_sync_rst = 1'b0;
    tick();
    exp_rsp_q.delete();
    mig_return();
    mig_return();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (rsp_valid !== 1'b0 || rd_err !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_discard: got rsp_valid=%b rd_err=%b want 0 1", rsp_valid, rd_err);
      end
      tick();
    end
  endtask

  task automatic test_stats();
    int           i, last, n;
    logic [511:0] exp;
    logic [31:0]  exp_wr, exp_rd;
`ifdef MIG_REQ_BRIDGE_STATS_EN
    exp_wr = 32'd3;
    exp_rd = 32'd2;
`else
    exp_wr = 32'd0;
    exp_rd = 32'd0;
`endif
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    i    = 0;
    last = -1;
    req_addr  = 28'h0003000;
    req_write = 1'b1;
    req_wdata = wr_pat(req_addr);
    req_be    = '1;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && i < 5; c++) begin
      if (req_ready === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (c - last != 2) begin
            miscompares++;
            $display("FAIL back_to_back: got interval %0d want 2", c - last);
          end
        end
        last = c;
        if (!req_write) exp_rsp_q.push_back(rd_pat(req_addr));
        i++;
        tick();
        req_addr  = 28'h0003000 + (28'(i) << 6);
        req_write = ((i % 2) == 0);
        req_wdata = wr_pat(req_addr);
        req_valid = (i < 5);
      end else begin
        tick();
      end
    end
    vectors++;
    if (i != 5) begin
      miscompares++;
      $display("FAIL stats_accept_timeout: got %0d accepts want 5", i);
    end
    tick();
    tick();
    mig_return();
    mig_return();
    rsp_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      exp = exp_rsp_q.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
        miscompares++;
        $display("FAIL stats_rsp j=%0d: got valid=%b data=%h want 1 %h", j, rsp_valid, rsp_data, exp);
      end
      tick();
    end
    rsp_ready = 1'b0;
    vectors++;
    if (stat_wr !== exp_wr || stat_rd !== exp_rd) begin
      miscompares++;
      $display("FAIL stats: got wr=%0d rd=%0d want %0d %0d", stat_wr, stat_rd, exp_wr, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b0;
    req_valid           = 1'b0;
    req_write           = 1'b0;
    req_addr            = '0;
    req_wdata           = '0;
    req_be              = '0;
    rsp_ready           = 1'b0;
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;
    app_rd_data         = '0;
    app_rd_data_valid   = 1'b0;
    repeat (3) @(posedge ui_clk);
    #1;
    test_reset();
    ui_clk_sync_rst = 1'b0;
    tick();
    tick();
    test_calib_hold();
    test_masked_write();
    test_split_write();
    test_credit_limit();
    test_reset_mid_read();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
